// File: rtl/lsu_ctrl.sv
// Load/store sequencer: accepts one decoded memory op, issues one aligned bus
// transaction with valid/ready handshakes and returns extended load data or a store ack.
module lsu_ctrl #(
    parameter int XLEN    = 64,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            ren_i,
    input  logic            wen_i,
    input  logic [7:0]      mask_i,
    input  logic            is_signed_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic            mem_req_valid_o,
    input  logic            mem_req_ready_i,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    output logic [7:0]      mem_wstrb_o,
    input  logic            mem_resp_valid_i,
    output logic            mem_resp_ready_o,
    input  logic [XLEN-1:0] mem_rdata_i,
    output logic            done_valid_o,
    input  logic            done_ready_i,
    output logic [XLEN-1:0] rdata_o,
    output logic            err_o
);

    localparam int OFF_W = $clog2(XLEN / 8);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic              signed_q, signed_d;
    logic [7:0]        mask_q, mask_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              bad_op_s;
    logic [XLEN-1:0]   shifted_s;

    // Truncate a right-justified load value to the access size and extend it.
    function automatic logic [XLEN-1:0] extend_load(input logic [XLEN-1:0] v,
                                                    input logic [7:0] m,
                                                    input logic s);
        case (m)
            8'h01:   return {{(XLEN-8){s & v[7]}}, v[7:0]};
            8'h03:   return {{(XLEN-16){s & v[15]}}, v[15:0]};
            8'h0F:   return {{(XLEN-32){s & v[31]}}, v[31:0]};
            8'hFF:   return v;
            default: return '0;
        endcase
    endfunction

    // Illegal or misaligned ops are answered locally without touching the bus.
    always_comb begin
        case (mask_i)
            8'h01:   bad_op_s = ren_i & wen_i;
            8'h03:   bad_op_s = (ren_i & wen_i) | addr_i[0];
            8'h0F:   bad_op_s = (ren_i & wen_i) | (addr_i[1:0] != 2'b00);
            8'hFF:   bad_op_s = (ren_i & wen_i) | (addr_i[2:0] != 3'b000);
            default: bad_op_s = 1'b1;
        endcase
    end

    assign shifted_s = mem_rdata_i >> {addr_q[OFF_W-1:0], 3'b000};

    // Next-state and datapath capture for the four-state sequencer.
    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        signed_d = signed_q;
        mask_d   = mask_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i && (ren_i || wen_i)) begin
                    we_d     = wen_i;
                    signed_d = is_signed_i;
                    mask_d   = mask_i;
                    addr_d   = addr_i;
                    wdata_d  = wdata_i;
                    rdata_d  = '0;
                    if (bad_op_s) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = REQ;
                        err_d   = 1'b0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (mem_req_ready_i) begin
                    state_d = RESP;
                    cnt_d   = '0;
                end else begin
                    state_d = REQ;
                end
            end
            RESP: begin
                cnt_d = cnt_q + CNT_ONE;
                // A response in the final allowed cycle takes priority over the abort.
                if (mem_resp_valid_i) begin
                    state_d = DONE;
                    err_d   = 1'b0;
                    rdata_d = we_q ? '0 : extend_load(shifted_s, mask_q, signed_q);
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    state_d = RESP;
                end
            end
            DONE: begin
                if (done_ready_i) begin
                    state_d = IDLE;
                    err_d   = 1'b0;
                    rdata_d = '0;
                end else begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and latched request registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            signed_q <= 1'b0;
            mask_q   <= 8'h00;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            signed_q <= signed_d;
            mask_q   <= mask_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign req_ready_o      = (state_q == IDLE);
    assign mem_req_valid_o  = (state_q == REQ);
    assign mem_we_o         = (state_q == REQ) & we_q;
    assign mem_addr_o       = (state_q == REQ) ? {addr_q[XLEN-1:OFF_W], {OFF_W{1'b0}}} : '0;
    assign mem_wdata_o      = mem_we_o ? (wdata_q << {addr_q[OFF_W-1:0], 3'b000}) : '0;
    assign mem_wstrb_o      = mem_we_o ? (mask_q << addr_q[OFF_W-1:0]) : 8'h00;
    assign mem_resp_ready_o = (state_q == RESP);
    assign done_valid_o     = (state_q == DONE);
    assign rdata_o          = rdata_q;
    assign err_o            = err_q;

endmodule
